usb_rx_nrzi_unstuff: RTL
========================

# usb_rx_nrzi_unstuff

Parametrised USB receive front end sitting between the bit-clock recovery (BCR) block and the packet decoder. It NRZI-decodes sampled J/K line states and detects SYNC. It removes stuffed bits, assembles LSB-first bytes and detects EOP. Protocol violations (stuff error, SE1, bad EOP, loss of lock) are flagged, and the block resynchronises on bus idle.

## Interface
- STUFF_LEN, 6: consecutive decoded 1s after which a stuffed 0 is expected.
- DATA_W, 8: assembled word width.
- LOW_SPEED, 0: 1 swaps the J/K mapping (low-speed J = 2'b10).
- SYNC_MIN_ZEROS, 5: minimum decoded 0s before the terminating 1 of SYNC.
- IDLE_BITS, 7: consecutive J strobes that end the ERROR state.
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- bit_strobe  in  1  one-cycle strobe marking a valid line_state sample
- phase_lock  in  1  BCR locked
- line_state  in  2  {D-,D+}; 00 = SE0, 11 = SE1, J/K per LOW_SPEED
- rx_data  out  DATA_W  assembled word, LSB first on the wire
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_active  out  1  high from SYNC completion until EOP or abort
- rx_eop  out  1  one-cycle pulse on a valid EOP
- rx_error  out  1  one-cycle pulse on any violation

## Operation
- A sample is taken only when bit_strobe && phase_lock.
- Decoded bit = 1 if the J/K value equals prev_jk, else 0.
- prev_jk updates on every J/K sample in every state. It resets to J.
- **IDLE**
  - A K sample enters SYNC with zero_cnt = 1.
  - J, SE0 and SE1 are ignored.
- **SYNC**
  - A decoded 0 increments zero_cnt, saturating.
  - A decoded 1 with zero_cnt >= SYNC_MIN_ZEROS enters DATA, sets rx_active, and clears ones_cnt and bit_cnt.
  - A decoded 1 with a smaller zero_cnt returns to IDLE.
  - SE0 or SE1 returns to IDLE. No error is flagged.
- **DATA**
  - A decoded 1 increments ones_cnt. A decoded 0 clears it.
  - When ones_cnt == STUFF_LEN, the next bit is a stuff bit:
    - 0: dropped, ones_cnt cleared, not shifted.
    - 1: rx_error pulse, enter ERROR.
  - A non-stuff bit shifts into the MSB of the shift register (right shift) and increments bit_cnt.
  - At bit_cnt == DATA_W: rx_data is loaded, rx_valid pulses and bit_cnt wraps to 0.
  - SE0 enters EOP_SE0. A partial word is discarded.
  - If bit_cnt >= 2 at that SE0, rx_error pulses. bit_cnt of 0 or 1 (dribble) is legal.
  - SE1 gives rx_error and ERROR.
- **EOP_SE0**
  - A second SE0 stays in EOP_SE0.
  - A third consecutive SE0 gives rx_error and ERROR.
  - J: rx_eop pulse, rx_active cleared, IDLE.
  - K or SE1: rx_error, ERROR.
- **ERROR**
  - rx_active is low.
  - An idle counter counts consecutive J samples. Any non-J sample clears it.
  - At IDLE_BITS, go to IDLE.
- **Loss of lock**
  - phase_lock falling while in SYNC returns to IDLE.
  - In DATA or EOP_SE0: rx_error pulse, ERROR, rx_active cleared.
- **Simultaneous events**
  - If a stuff error occurs on the same sample that completes a word, the word is not emitted. rx_error wins.

## Timing
- Reset values: rx_data 0, rx_valid 0, rx_active 0, rx_eop 0, rx_error 0, state IDLE, prev_jk J, all counters 0.
- All outputs are registered. Each pulse is high exactly one clk, in the cycle after the qualifying strobe.
- rx_data holds its value until the next rx_valid.
- rx_active rises one clk after the strobe carrying the final SYNC bit. It falls together with rx_eop or rx_error.
- At most one of rx_valid / rx_eop / rx_error is high per cycle, except rx_error with a concurrent abort.
- Reset mid-packet returns to IDLE the next cycle. Nothing is emitted.
- Strobes are at least 2 clk apart. No back-to-back strobe handling is required.

## Structure
- Shared package usb_rx_pkg holds:
  - line-state constants LS_SE0, LS_J_FS, LS_K_FS, LS_SE1;
  - the state enum rx_state_e {IDLE, SYNC, DATA, EOP_SE0, ERROR}.
- One sub-module, usb_unstuff_core, holds the ones counter and stuff-bit decision. Its outputs are bit_keep and stuff_err.

## Test plan
- Idle J, then K J K J K J K K, then byte 0xA5 NRZI-encoded, then SE0 SE0 J -> rx_active rises after SYNC, rx_valid with rx_data 0xA5, rx_eop pulse, rx_active falls, rx_error never asserted.
- Payload 0xFF 0xFF with stuffing inserted -> rx_data 0xFF twice, stuffed 0s removed, no error.
- Seven decoded 1s without a stuffed 0 -> rx_error one cycle, rx_active low; 7 J samples then a valid packet -> packet received normally.
- SE0 after 3 bits of a partial word -> rx_error plus EOP_SE0. SE0 after 1 dribble bit then J -> rx_eop only.
- Drop phase_lock mid-byte -> rx_error pulse, no rx_valid. Packet with LOW_SPEED=1 and swapped line states -> identical rx_data.
- Assert rst_n low mid-byte -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive front end: line states, FSM states
// and the low-speed J/K remap helper.
package usb_rx_pkg;

   localparam logic [1:0] LS_SE0  = 2'b00;
   localparam logic [1:0] LS_J_FS = 2'b01;
   localparam logic [1:0] LS_K_FS = 2'b10;
   localparam logic [1:0] LS_SE1  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_SE0,
      ERROR
   } rx_state_e;

   // Low-speed J/K are the mirror of full-speed; SE0/SE1 are symmetric anyway.
   function automatic logic [1:0] ls_to_fs(input logic [1:0] ls, input logic low_speed);
      if (low_speed && (ls == LS_J_FS || ls == LS_K_FS))
         return {ls[0], ls[1]};
      return ls;
   endfunction

endpackage

// File: rtl/usb_rx_nrzi_unstuff_if.sv
// Bundle between the bit-clock recovery block, the receive front end and the
// packet decoder.
interface usb_rx_nrzi_unstuff_if #(
   parameter int DATA_W = 8
);

   logic              bit_strobe;
   logic              phase_lock;
   logic [1:0]        line_state;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_active;
   logic              rx_eop;
   logic              rx_error;

   modport master (
      output bit_strobe, phase_lock, line_state,
      input  rx_data, rx_valid, rx_active, rx_eop, rx_error
   );

   modport slave (
      input  bit_strobe, phase_lock, line_state,
      output rx_data, rx_valid, rx_active, rx_eop, rx_error
   );

endinterface

// File: rtl/usb_unstuff_core.sv
// Bit-unstuffing decision: tracks consecutive decoded 1s and classifies the
// bit that follows a full run as a stuff bit.
module usb_unstuff_core #(
   parameter int STUFF_LEN = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic bit_en,
   input  logic bit_in,
   output logic bit_keep,
   output logic stuff_err
);

   localparam int                OC_W     = $clog2(STUFF_LEN + 1);
   localparam logic [OC_W-1:0]   OC_STUFF = OC_W'(STUFF_LEN);

   logic [OC_W-1:0] ones_cnt;
   logic            stuff_slot;

   assign stuff_slot = (ones_cnt == OC_STUFF);
   assign bit_keep   = bit_en && !stuff_slot;
   assign stuff_err  = bit_en && stuff_slot && bit_in;

   // A stuff slot always restarts the run, whether the bit was a legal 0 or not.
   always_ff @(posedge clk) begin
      if (!rst_n || clear)
         ones_cnt <= '0;
      else if (bit_en)
         ones_cnt <= (stuff_slot || !bit_in) ? '0 : ones_cnt + 1'b1;
   end

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive front end: NRZI decode, SYNC detect, bit unstuffing, LSB-first
// word assembly, EOP detection and violation handling with idle resync.
module usb_rx_nrzi_unstuff
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LEN      = 6,
   parameter int DATA_W         = 8,
   parameter int LOW_SPEED      = 0,
   parameter int SYNC_MIN_ZEROS = 5,
   parameter int IDLE_BITS      = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   usb_rx_nrzi_unstuff_if.slave bus
);

   localparam int              ZC_W    = $clog2(SYNC_MIN_ZEROS + 2);
   localparam int              BC_W    = $clog2(DATA_W + 1);
   localparam int              IC_W    = $clog2(IDLE_BITS + 1);
   localparam logic [ZC_W-1:0] ZC_ONE  = ZC_W'(1);
   localparam logic [ZC_W-1:0] ZC_MIN  = ZC_W'(SYNC_MIN_ZEROS);
   localparam logic [BC_W-1:0] BC_TWO  = BC_W'(2);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);
   localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_BITS - 1);

   function automatic logic [ZC_W-1:0] sat_inc_zc(input logic [ZC_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   rx_state_e         state, state_n;
   logic [ZC_W-1:0]   zero_cnt, zero_n;
   logic [BC_W-1:0]   bit_cnt, bit_n;
   logic [1:0]        se0_cnt, se0_n;
   logic [IC_W-1:0]   idle_cnt, idle_n;
   logic              prev_jk;
   logic              lock_q;
   logic              rx_valid_q, rx_eop_q, rx_error_q, rx_active_q;
   logic              valid_n, eop_n, err_n, active_n;
   logic              enter_data, shift_en, load_word, abort;
   logic [DATA_W-1:0] shreg, shreg_nxt, rx_data_q;

   logic       smp;
   logic [1:0] ls_fs;
   logic       is_j, is_k, is_se0, is_se1, is_jk;
   logic       dec_bit, lock_fall;
   logic       core_en, bit_keep, stuff_err;

   assign smp       = bus.bit_strobe && bus.phase_lock;
   assign ls_fs     = ls_to_fs(bus.line_state, LOW_SPEED != 0);
   assign is_j      = (ls_fs == LS_J_FS);
   assign is_k      = (ls_fs == LS_K_FS);
   assign is_se0    = (ls_fs == LS_SE0);
   assign is_se1    = (ls_fs == LS_SE1);
   assign is_jk     = is_j || is_k;
   assign dec_bit   = (is_j == prev_jk);
   assign lock_fall = lock_q && !bus.phase_lock;
   assign core_en   = smp && is_jk && (state == DATA);
   assign shreg_nxt = {dec_bit, shreg[DATA_W-1:1]};

   usb_unstuff_core #(
      .STUFF_LEN (STUFF_LEN)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (enter_data),
      .bit_en    (core_en),
      .bit_in    (dec_bit),
      .bit_keep  (bit_keep),
      .stuff_err (stuff_err)
   );

   always_comb begin
      state_n    = state;
      zero_n     = zero_cnt;
      bit_n      = bit_cnt;
      se0_n      = se0_cnt;
      idle_n     = idle_cnt;
      valid_n    = 1'b0;
      eop_n      = 1'b0;
      err_n      = 1'b0;
      active_n   = rx_active_q;
      enter_data = 1'b0;
      shift_en   = 1'b0;
      load_word  = 1'b0;
      abort      = 1'b0;

      unique case (state)
         IDLE: begin
            if (smp && is_k) begin
               state_n = SYNC;
               zero_n  = ZC_ONE;
            end
         end

         SYNC: begin
            if (lock_fall)
               state_n = IDLE;
            else if (smp) begin
               if (!is_jk)
                  state_n = IDLE;
               else if (!dec_bit)
                  zero_n = sat_inc_zc(zero_cnt);
               else if (zero_cnt >= ZC_MIN) begin
                  state_n    = DATA;
                  active_n   = 1'b1;
                  enter_data = 1'b1;
                  bit_n      = '0;
               end else
                  state_n = IDLE;
            end
         end

         DATA: begin
            if (lock_fall)
               abort = 1'b1;
            else if (smp) begin
               if (is_se0) begin
                  // Up to one dribble bit past a word boundary is tolerated.
                  state_n = EOP_SE0;
                  se0_n   = 2'd1;
                  bit_n   = '0;
                  if (bit_cnt >= BC_TWO) begin
                     err_n    = 1'b1;
                     active_n = 1'b0;
                  end
               end else if (is_se1 || stuff_err)
                  abort = 1'b1;
               else if (bit_keep) begin
                  shift_en = 1'b1;
                  if (bit_cnt == BC_LAST) begin
                     load_word = 1'b1;
                     valid_n   = 1'b1;
                     bit_n     = '0;
                  end else
                     bit_n = bit_cnt + 1'b1;
               end
            end
         end

         EOP_SE0: begin
            if (lock_fall)
               abort = 1'b1;
            else if (smp) begin
               if (is_se0) begin
                  if (se0_cnt == 2'd2)
                     abort = 1'b1;
                  else
                     se0_n = se0_cnt + 1'b1;
               end else if (is_j) begin
                  eop_n    = 1'b1;
                  active_n = 1'b0;
                  state_n  = IDLE;
               end else
                  abort = 1'b1;
            end
         end

         ERROR: begin
            if (smp) begin
               if (!is_j)
                  idle_n = '0;
               else if (idle_cnt == IC_LAST) begin
                  idle_n  = '0;
                  state_n = IDLE;
               end else
                  idle_n = idle_cnt + 1'b1;
            end
         end

         default: state_n = IDLE;
      endcase

      if (abort) begin
         state_n  = ERROR;
         err_n    = 1'b1;
         active_n = 1'b0;
         idle_n   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         zero_cnt    <= '0;
         bit_cnt     <= '0;
         se0_cnt     <= '0;
         idle_cnt    <= '0;
         prev_jk     <= 1'b1;
         lock_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_eop_q    <= 1'b0;
         rx_error_q  <= 1'b0;
         rx_active_q <= 1'b0;
      end else begin
         state       <= state_n;
         zero_cnt    <= zero_n;
         bit_cnt     <= bit_n;
         se0_cnt     <= se0_n;
         idle_cnt    <= idle_n;
         lock_q      <= bus.phase_lock;
         rx_valid_q  <= valid_n;
         rx_eop_q    <= eop_n;
         rx_error_q  <= err_n;
         rx_active_q <= active_n;
         if (smp && is_jk)
            prev_jk <= is_j;
      end
   end

   // Word assembly: the shift register itself carries no reset.
   always_ff @(posedge clk) begin
      if (shift_en)
         shreg <= shreg_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         rx_data_q <= '0;
      else if (load_word)
         rx_data_q <= shreg_nxt;
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_active = rx_active_q;
   assign bus.rx_eop    = rx_eop_q;
   assign bus.rx_error  = rx_error_q;

endmodule
